// File: rtl/seq_chunk_comparator_if.sv
// Handshake and operand bundle for seq_chunk_comparator.
//
// Handshake semantics: a compare request is taken on a rising edge where
// start=1 and the block is not busy (IDLE or DONE state). a, b and
// signed_mode are captured on that same edge. busy stays high while chunks
// are being scanned. done pulses for one cycle, and the result flags are
// updated on the same edge. start seen while busy=1 is dropped, not queued.
interface seq_chunk_comparator_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             equal;
  logic             lower;
  logic             greater;

  // Requester side: drives the operands, observes the status and result.
  modport master (
    output start, signed_mode, a, b,
    input  busy, done, equal, lower, greater
  );

  // Comparator side.
  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, equal, lower, greater
  );
endinterface

// File: rtl/seq_chunk_comparator.sv
// Multi-cycle MSB-first magnitude comparator. Each cycle it examines one
// CHUNK-bit slice of the captured operands and stops at the first slice
// that differs, so the latency depends on the data: 1..NCHUNK cycles.
// Two's-complement mode needs special handling only on the top slice:
// if the sign bits differ, the negative operand is lower. When the sign
// bits match, plain unsigned slice ordering gives the signed order too.
// WIDTH must be a multiple of CHUNK and at least 2.
module seq_chunk_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_chunk_comparator_if.slave bus,
  output logic [1:0]            dbg_state_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sgn_q;
  logic [IDXW-1:0]  idx_q;
  logic             busy_q;
  logic             done_q;
  logic             equal_q;
  logic             lower_q;
  logic             greater_q;

  // Slice under inspection and the decision it produces this cycle.
  logic [CHUNK-1:0] cur_a;
  logic [CHUNK-1:0] cur_b;
  logic             sign_split;
  logic             cmp_decided;
  logic             cmp_lower;

  // Select the current slice of each captured operand and classify it.
  always_comb begin
    cur_a = '0;
    cur_b = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) begin
        cur_a = a_q[i*CHUNK +: CHUNK];
        cur_b = b_q[i*CHUNK +: CHUNK];
      end
    end
    // Only the top slice carries the sign, so the signed override is
    // limited to the first compare cycle.
    sign_split  = sgn_q && (idx_q == LAST_IDX) &&
                  (a_q[WIDTH-1] != b_q[WIDTH-1]);
    cmp_decided = sign_split || (cur_a != cur_b);
    cmp_lower   = sign_split ? a_q[WIDTH-1] : (cur_a < cur_b);
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      equal_q   <= 1'b0;
      lower_q   <= 1'b0;
      greater_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            sgn_q   <= bus.signed_mode;
            idx_q   <= LAST_IDX;
            busy_q  <= 1'b1;
            state_q <= S_COMPARE;
          end
        end

        S_COMPARE: begin
          // A start seen here is dropped on purpose; the request is not held.
          if (cmp_decided) begin
            equal_q   <= 1'b0;
            lower_q   <= cmp_lower;
            greater_q <= ~cmp_lower;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else if (idx_q == '0) begin
            equal_q   <= 1'b1;
            lower_q   <= 1'b0;
            greater_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end

        S_DONE: begin
          done_q <= 1'b0;
          // Back-to-back request: accept directly from the result cycle.
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            sgn_q   <= bus.signed_mode;
            idx_q   <= LAST_IDX;
            busy_q  <= 1'b1;
            state_q <= S_COMPARE;
          end else begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.equal   = equal_q;
  assign bus.lower   = lower_q;
  assign bus.greater = greater_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_chunk_comparator.sv
// Directed bench for seq_chunk_comparator (WIDTH=16, CHUNK=4).
module tb_seq_chunk_comparator;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  seq_chunk_comparator_if #(.WIDTH(WIDTH)) ifc ();

  seq_chunk_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (ifc),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] prev_res = 3'b000;   // {equal, lower, greater}
  logic [2:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        sm;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  k;
    logic        eq;
    logic        lt;
    logic        gt;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  // ---------------- driver tasks ----------------
  // Raise start for one edge; returns 1 ns after the accepting edge.
  task automatic drive_start(input logic sm, input logic [15:0] a,
                             input logic [15:0] b);
    @(negedge clk);
    ifc.start       = 1'b1;
    ifc.signed_mode = sm;
    ifc.a           = a;
    ifc.b           = b;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
  endtask

  // Count edges until done, and busy-high cycles seen before it.
  task automatic wait_done(output int k, output int busy_cyc, output bit timeout);
    k        = 0;
    busy_cyc = 0;
    timeout  = 1'b1;
    for (int c = 1; c <= NCHUNK + 4; c++) begin
      if (ifc.busy) busy_cyc++;
      @(posedge clk);
      #1;
      if (ifc.done) begin
        k       = c;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [3:0] k_exp,
                              input logic eq, input logic lt, input logic gt,
                              input int k, input int busy_cyc, input bit timeout);
    logic [2:0] exp_res;
    exp_q.push_back({eq, lt, gt});
    exp_res = exp_q.pop_front();
    check({tag, " timeout"}, 32'(timeout), 32'd0);
    check({tag, " latency"}, 32'(k), 32'(k_exp));
    check({tag, " busy_cycles"}, 32'(busy_cyc), 32'(k_exp));
    check({tag, " busy_at_done"}, 32'(ifc.busy), 32'd0);
    check({tag, " result"}, 32'({ifc.equal, ifc.lower, ifc.greater}), 32'(exp_res));
    prev_res = exp_res;
  endtask

  // ---------------- test ----------------
  initial begin
    int  k, bc, cnt, first_c;
    bit  to;
    logic [2:0] first_res;

    vecs[0]  = '{1'b0, 16'h1234, 16'h1234, 4'd4, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 16'h8000, 16'h7FFF, 4'd1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 16'h8000, 16'h7FFF, 4'd1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 16'h12A4, 16'h1254, 4'd3, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 16'hFFFF, 16'hFFFE, 4'd4, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 16'hFFFF, 16'h0001, 4'd1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 16'h0000, 16'h0000, 4'd4, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 16'h7000, 16'h8000, 4'd1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 16'h0F00, 16'h0E00, 4'd2, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 16'h0001, 16'h0002, 4'd4, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 16'hFFF0, 16'hFFFF, 4'd4, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 16'hFFFF, 16'hFFFF, 4'd4, 1'b1, 1'b0, 1'b0};

    ifc.start       = 1'b0;
    ifc.signed_mode = 1'b0;
    ifc.a           = '0;
    ifc.b           = '0;
    rst             = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy",    32'(ifc.busy),    32'd0);
    check("reset done",    32'(ifc.done),    32'd0);
    check("reset result",  32'({ifc.equal, ifc.lower, ifc.greater}), 32'd0);
    check("reset state",   32'(dbg_state),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven compares.
    for (int i = 0; i < NVEC; i++) begin
      drive_start(vecs[i].sm, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d busy_after_start", i), 32'(ifc.busy), 32'd1);
      check($sformatf("vec%0d result_held", i),
            32'({ifc.equal, ifc.lower, ifc.greater}), 32'(prev_res));
      wait_done(k, bc, to);
      check_result($sformatf("vec%0d", i), vecs[i].k, vecs[i].eq, vecs[i].lt,
                   vecs[i].gt, k, bc, to);
    end

    // Operand changes after acceptance are ignored.
    drive_start(1'b0, 16'h12A4, 16'h1254);
    ifc.a           = 16'h0000;
    ifc.b           = 16'hFFFF;
    ifc.signed_mode = 1'b1;
    wait_done(k, bc, to);
    check_result("late_operand", 4'd3, 1'b0, 1'b0, 1'b1, k, bc, to);

    // done lasts one cycle.
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(ifc.done), 32'd0);
    check("idle_after_done", 32'(dbg_state), 32'd0);

    // Back-to-back: start held during the DONE cycle.
    drive_start(1'b1, 16'hFFFF, 16'hFFFE);
    wait_done(k, bc, to);
    check_result("b2b_first", 4'd4, 1'b0, 1'b0, 1'b1, k, bc, to);
    ifc.start       = 1'b1;
    ifc.signed_mode = 1'b1;
    ifc.a           = 16'hFFFF;
    ifc.b           = 16'h0001;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    check("b2b busy_after_start", 32'(ifc.busy), 32'd1);
    wait_done(k, bc, to);
    check_result("b2b_second", 4'd1, 1'b0, 1'b1, 1'b0, k, bc, to);

    // start while busy is ignored: one done, original result, k=4.
    drive_start(1'b0, 16'h0001, 16'h0002);
    cnt       = 0;
    first_c   = 0;
    first_res = 3'b000;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 2) begin
        ifc.start       = 1'b1;
        ifc.signed_mode = 1'b1;
        ifc.a           = 16'hFFFF;
        ifc.b           = 16'h0000;
      end else begin
        ifc.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (ifc.done) begin
        cnt++;
        if (cnt == 1) begin
          first_c   = c;
          first_res = {ifc.equal, ifc.lower, ifc.greater};
        end
      end
    end
    ifc.start = 1'b0;
    check("busy_start done_count", 32'(cnt), 32'd1);
    check("busy_start latency", 32'(first_c), 32'd4);
    check("busy_start result", 32'(first_res), 32'b010);
    prev_res = 3'b010;

    // Asynchronous reset mid-compare.
    drive_start(1'b0, 16'h1234, 16'h1234);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst busy",   32'(ifc.busy), 32'd0);
    check("async_rst done",   32'(ifc.done), 32'd0);
    check("async_rst result", 32'({ifc.equal, ifc.lower, ifc.greater}), 32'd0);
    check("async_rst state",  32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (ifc.done) cnt++;
    end
    check("async_rst no_done", 32'(cnt), 32'd0);
    prev_res = 3'b000;
    drive_start(1'b0, 16'h1234, 16'h1234);
    check("post_rst result_held", 32'({ifc.equal, ifc.lower, ifc.greater}), 32'd0);
    wait_done(k, bc, to);
    check_result("post_rst", 4'd4, 1'b1, 1'b0, 1'b0, k, bc, to);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_chunk_comparator.md
Name: seq_chunk_comparator

Overview:
- Parametrised, multi-cycle magnitude comparator for two WIDTH-bit operands.
- Scans the operands MSB-first, CHUNK bits per clock, and stops at the first differing chunk.
- Supports unsigned and two's-complement signed modes, with a start/busy/done handshake.
- Successor to the 4-bit combinational comparator, for wide datapaths where a single-cycle wide compare would break timing.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK and at least 2.
- CHUNK, 4, bits compared per clock cycle. NCHUNK = WIDTH/CHUNK gives the maximum number of compare cycles.

Ports:
- clk  input  1  rising-edge clock; the only clock in the block.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a compare. Accepted only when busy=0.
- signed_mode  input  1  1 selects two's-complement compare, 0 selects unsigned. Sampled with start.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse when the result becomes valid.
- equal  output  1  A == B.
- lower  output  1  A < B.
- greater  output  1  A > B.

Behaviour:
- Reset (async, immediate): state=IDLE; busy, done, equal, lower, greater all 0; chunk index cleared.
- States: IDLE, COMPARE, DONE.
- IDLE, start=1 at a rising edge:
  - Register a, b and signed_mode.
  - Set chunk index to NCHUNK-1 (the MSB chunk).
  - Go to COMPARE; busy=1.
- COMPARE, one chunk per cycle, always using the registered operands:
  - Signed mode, MSB chunk, sign bits differ: the operand with sign bit 1 is lower. Decide immediately.
  - All other cases: compare the current chunks as unsigned values. With equal sign bits, unsigned ordering matches signed ordering.
  - Chunks differ: register lower/greater (equal=0), go to DONE.
  - Chunks equal and index=0: register equal=1, go to DONE.
  - Otherwise: decrement the index and stay in COMPARE.
- Latency:
  - k = (number of leading equal chunks) + 1, with 1 ≤ k ≤ NCHUNK.
  - busy is high for exactly k cycles.
  - done=1 and the new equal/lower/greater values appear together, k rising edges after the edge that accepted start.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - Next state is IDLE, unless start=1 in that cycle. In that case the new operands are accepted and the state goes to COMPARE (back-to-back compares allowed).
- Result outputs:
  - Registered and exactly one-hot once the first compare completes.
  - Hold their value until the next done pulse; they do not clear when a new compare starts.
- start while busy=1 is ignored. It is not queued and does not affect the result.
- Changes on a, b or signed_mode after acceptance have no effect on the current compare.
- Reset during COMPARE or DONE aborts the operation. All outputs go to 0 asynchronously, and no done pulse is produced for the aborted compare.

Test Plan:
1. WIDTH=16, CHUNK=4, unsigned, a=0x1234, b=0x1234, start for 1 cycle -> busy high 4 cycles; done pulses on the 4th edge after start; equal=1, lower=0, greater=0.
2. Unsigned a=0x8000, b=0x7FFF -> k=1, greater=1. Same operands with signed_mode=1 -> k=1, lower=1.
3. Unsigned a=0x12A4, b=0x1254 -> decided on the third chunk (A vs 5), k=3, greater=1. Drive a=0x0000 during busy -> result unchanged.
4. Signed a=0xFFFF (-1), b=0xFFFE (-2) -> k=4, greater=1. Then, with start held high in the DONE cycle, signed a=0xFFFF, b=0x0001 -> accepted back-to-back, k=1, lower=1.
5. start pulsed again while busy=1 with different operands -> ignored; only one done pulse, carrying the original result.
6. Assert rst mid-COMPARE (a=0x1234, b=0x1234, after 2 cycles) -> busy, done, equal, lower, greater all 0 immediately with no clock edge needed; no done pulse follows. A subsequent start completes normally.
